apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- APB master bridge that shares one APB bus between NUM_REQ on-chip requesters.
- Accepts a simple valid/ready request from each requester and arbitrates round-robin.
- Sequences the APB IDLE/SETUP/ACCESS phases and supports slave wait states.
- Returns read data and error status to the requester that was granted; a watchdog aborts transfers stuck in ACCESS.

Parameters:
- NUM_REQ, 2: number of requesters (>=1).
- ADDR_W, 8: APB address width.
- DATA_W, 8: APB data width.
- TIMEOUT, 16: maximum ACCESS cycles with pready low before abort; 0 disables the watchdog.

Ports:
- pclk  in  1  bus clock; all logic on rising edge.
- prst  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address, requester i at slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data, same slicing.
- req_write  in  NUM_REQ  1=write, 0=read.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DATA_W  read data; 0 on writes and aborts.
- rsp_err  out  1  pslverr or timeout; qualified by any rsp_valid bit.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB slave ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Clocking and reset: one clock, pclk. Reset prst is synchronous and active-low.
- While prst=0 at a pclk edge:
  - state=IDLE; round-robin pointer=0; watchdog counter=0.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0.
  - req_ready is forced to 0 during reset.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready is combinational. It is one-hot at the first requester with req_valid=1, searching from the pointer upward with wrap-around; it is 0 if no request is pending.
  - A request is accepted when req_valid[i] && req_ready[i] at a pclk edge.
  - On acceptance, register grant index g and paddr/pwdata/pwrite from slice g. pwdata is forced to 0 for reads.
  - Set pointer to (g+1) mod NUM_REQ, and go to SETUP.
  - req_ready is 0 in every state except IDLE.
- SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite and pwdata hold stable.
  - Edge with pready=1:
    - Complete the transfer and go to IDLE.
    - Next cycle: rsp_valid[g]=1, rsp_rdata=(pwrite?0:prdata), rsp_err=pslverr, psel=0, penable=0.
  - Edge with pready=0: increment the watchdog counter.
  - Abort: when the counter reaches TIMEOUT and TIMEOUT!=0, go to IDLE with psel=penable=0, then rsp_valid[g]=1, rsp_rdata=0, rsp_err=1.
  - The watchdog counter clears on entry to SETUP. Its width is $clog2(TIMEOUT+1), minimum 1.
- Responses:
  - rsp_valid is a single-cycle pulse.
  - rsp_rdata and rsp_err hold their last value otherwise.
  - pslverr is sampled only at the completion edge.
- Latency, zero-wait slave:
  - Accept in cycle C0, SETUP in C1, ACCESS in C2, rsp_valid in C3.
  - A new request may be accepted in C3, the same cycle as rsp_valid, so peak throughput is one transfer per 3 cycles.
- Wait states: each pready=0 cycle in ACCESS adds one cycle of latency.
- Simultaneous requests: only one grant per IDLE cycle. The losers keep req_valid high and are served in pointer order. No requester waits more than NUM_REQ-1 other transfers.
- Requester contract: req_valid and payload stay stable until accepted. The block does not check this.
- Reset mid-transfer: abandon the transfer, with psel and penable low in the cycle after the reset edge. No rsp_valid is generated for the abandoned transfer.

Test Plan:
- Write, zero-wait: requester 0 write addr=0x12, data=0xA5, pready=1 -> psel rises in C1, penable in C2 with paddr=0x12 and pwdata=0xA5; rsp_valid[0]=1, rsp_err=0, rsp_rdata=0 in C3.
- Read, zero-wait: requester 1 read addr=0x34, slave returns prdata=0x5C -> rsp_valid[1] in C3 with rsp_rdata=0x5C; pwrite=0 throughout.
- Contention: both requesters valid from reset, 4 transfers each -> grants alternate 0,1,0,1,...; each transfer completes in 3 cycles with no idle gap.
- Wait states: pready low for 3 ACCESS cycles -> paddr/pwrite/pwdata/psel/penable stable; rsp_valid appears 3 cycles later than the zero-wait case.
- Errors: pslverr=1 at completion -> rsp_err=1. pready stuck low with TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, psel=0, bus idle afterwards.
- Reset mid-ACCESS: assert prst=0 during ACCESS -> psel=penable=0 next cycle; no rsp_valid; pointer=0; a fresh request after release completes normally.

Source files
------------

// File: rtl/apb_master_arbiter_if.sv
// Bundle of requester handshakes and APB bus signals for apb_master_arbiter.
// master = the arbiter itself; slave = requesters plus the APB completer.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      psel;
  logic                      penable;
  logic [ADDR_W-1:0]         paddr;
  logic                      pwrite;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  req_valid, req_addr, req_wdata, req_write, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_write, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master shared by NUM_REQ requesters, with wait-state support
// and an ACCESS-phase watchdog that aborts transfers the completer never finishes.
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic                 pclk,
  input logic                 prst,
  apb_master_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    gnt;
  logic [WD_W-1:0]     wd_cnt;

  logic                found;
  logic [IDX_W-1:0]    pick;
  logic [NUM_REQ-1:0]  ready;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic                pick_write;

  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  // Two passes give the rotating priority: first requesters at or above the
  // pointer, then the wrapped-around ones below it.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no latch is inferred.
    found      = 1'b0;
    pick       = '0;
    ready      = '0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        pick_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        pick_write = bus.req_write[i];
        ready[i]   = prst && (state == IDLE) && found;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge pclk) begin
    if (!prst) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt         <= '0;
      wd_cnt      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt      <= pick;
            paddr_q  <= pick_addr;
            pwrite_q <= pick_write;
            pwdata_q <= pick_write ? pick_wdata : '0;
            ptr      <= (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            wd_cnt   <= '0;
            psel_q   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << gnt;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q   <= bus.pslverr;
            state       <= IDLE;
          end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
            // This is the TIMEOUT-th stalled ACCESS cycle: give up on the completer.
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << gnt;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-level timeline model.
module tb_apb_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  logic prst;
  always #5 pclk = ~pclk;

  apb_master_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk),
    .prst(prst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int                wait_n;
    logic [DATA_W-1:0] rdata;
    bit                err;
  } plan_t;

  plan_t plan_q[$];

  // Requester side: one outstanding request per requester.
  bit                pend    [NUM_REQ];
  logic [ADDR_W-1:0] r_addr  [NUM_REQ];
  logic [DATA_W-1:0] r_wdata [NUM_REQ];
  bit                r_write [NUM_REQ];

  // Transfer timeline: age counts cycles since acceptance (1 = SETUP, 2.. = ACCESS).
  int                rr_ptr;
  bit                busy;
  int                age;
  int                acc_len;
  int                cur_g;
  int                cur_wait;
  bit                cur_stuck;
  bit                cur_write;
  logic [DATA_W-1:0] cur_rdata;
  bit                cur_err;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;
  bit                exp_write;
  bit                bus_zero;
  logic [NUM_REQ-1:0] rsp_exp;
  logic [DATA_W-1:0] last_rdata;
  bit                last_err;
  bit                live = 1'b0;

  int post_pct   = 0;
  bit hold_reset = 1'b1;
  int rsp_seen   = 0;

  function automatic int pick_req();
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (rr_ptr + k) % NUM_REQ;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int    r;
    r = $urandom_range(99);
    if (r < 3)       p.wait_n = TIMEOUT;
    else if (r < 10) p.wait_n = $urandom_range(TIMEOUT - 1, 4);
    else             p.wait_n = $urandom_range(2, 0);
    p.rdata = DATA_W'($urandom);
    p.err   = ($urandom_range(99) < 15);
    return p;
  endfunction

  task automatic post_req(input int i, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input bit w);
    pend[i]    = 1'b1;
    r_addr[i]  = a;
    r_wdata[i] = d;
    r_write[i] = w;
  endtask

  task automatic push_plan(input int w, input logic [DATA_W-1:0] rd, input bit e);
    plan_t p;
    p.wait_n = w;
    p.rdata  = rd;
    p.err    = e;
    plan_q.push_back(p);
  endtask

  // One clock cycle: compare registered outputs, drive stimulus, compare
  // req_ready, then advance the model across the coming rising edge.
  task automatic step();
    int                 g;
    bit                 in_access;
    bit                 rdy;
    logic [NUM_REQ-1:0] exp_ready;
    plan_t              p;

    @(negedge pclk);
    if (live) begin
      check("psel",      bus.psel,      busy);
      check("penable",   bus.penable,   busy && (age >= 2));
      check("rsp_valid", bus.rsp_valid, rsp_exp);
      check("rsp_rdata", bus.rsp_rdata, last_rdata);
      check("rsp_err",   bus.rsp_err,   last_err);
      if (busy || bus_zero) begin
        check("paddr",  bus.paddr,  exp_addr);
        check("pwrite", bus.pwrite, exp_write);
        check("pwdata", bus.pwdata, exp_wdata);
      end
    end
    if (bus.rsp_valid != '0) rsp_seen++;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pend[i] && (post_pct > 0) && ($urandom_range(99) < post_pct))
        post_req(i, ADDR_W'($urandom), DATA_W'($urandom), 1'($urandom_range(1)));
      bus.req_valid[i]                   = pend[i];
      bus.req_addr[i*ADDR_W +: ADDR_W]   = pend[i] ? r_addr[i]  : ADDR_W'($urandom);
      bus.req_wdata[i*DATA_W +: DATA_W]  = pend[i] ? r_wdata[i] : DATA_W'($urandom);
      bus.req_write[i]                   = pend[i] ? r_write[i] : 1'($urandom_range(1));
    end

    in_access = busy && (age >= 2);
    if (in_access) rdy = !cur_stuck && ((age - 2) == cur_wait);
    else           rdy = 1'($urandom_range(1));
    bus.pready  = rdy;
    bus.prdata  = (in_access && rdy) ? cur_rdata : DATA_W'($urandom);
    bus.pslverr = (in_access && rdy) ? cur_err   : 1'($urandom_range(1));
    prst        = !hold_reset;

    #1;
    g = (hold_reset || busy) ? -1 : pick_req();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    if (live) check("req_ready", bus.req_ready, exp_ready);

    rsp_exp = '0;
    if (hold_reset) begin
      busy       = 1'b0;
      rr_ptr     = 0;
      last_rdata = '0;
      last_err   = 1'b0;
      bus_zero   = 1'b1;
      exp_addr   = '0;
      exp_wdata  = '0;
      exp_write  = 1'b0;
      live       = 1'b1;
    end else if (busy) begin
      if (age == 1 + acc_len) begin
        busy           = 1'b0;
        rsp_exp[cur_g] = 1'b1;
        last_rdata     = (cur_stuck || cur_write) ? '0 : cur_rdata;
        last_err       = cur_stuck ? 1'b1 : cur_err;
      end else begin
        age++;
      end
    end else if (g >= 0) begin
      cur_g     = g;
      pend[g]   = 1'b0;
      exp_addr  = r_addr[g];
      exp_write = r_write[g];
      exp_wdata = r_write[g] ? r_wdata[g] : '0;
      cur_write = r_write[g];
      p = (plan_q.size() > 0) ? plan_q.pop_front() : rand_plan();
      cur_wait  = p.wait_n;
      cur_rdata = p.rdata;
      cur_err   = p.err;
      cur_stuck = (TIMEOUT > 0) && (cur_wait >= TIMEOUT);
      acc_len   = cur_stuck ? TIMEOUT : cur_wait + 1;
      rr_ptr    = (g + 1) % NUM_REQ;
      busy      = 1'b1;
      age       = 1;
      bus_zero  = 1'b0;
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_write = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    prst          = 1'b0;

    hold_reset = 1'b1;
    steps(3);
    hold_reset = 1'b0;
    steps(2);

    // Zero-wait write from requester 0.
    post_req(0, 8'h12, 8'hA5, 1'b1);
    push_plan(0, 8'h3C, 1'b0);
    steps(3);
    check("wr_access", {bus.psel, bus.penable, bus.paddr, bus.pwdata}, {1'b1, 1'b1, 8'h12, 8'hA5});
    step();
    check("wr_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b01, 1'b0, 8'h00});
    steps(2);

    // Zero-wait read from requester 1.
    post_req(1, 8'h34, 8'hEE, 1'b0);
    push_plan(0, 8'h5C, 1'b0);
    steps(4);
    check("rd_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b10, 1'b0, 8'h5C});
    steps(2);

    // Three wait states.
    post_req(0, 8'h56, 8'h99, 1'b1);
    push_plan(3, 8'h00, 1'b0);
    steps(7);
    check("wait_rsp", bus.rsp_valid, 2'b01);
    steps(2);

    // Slave error on a read with one wait state.
    post_req(1, 8'h78, 8'h00, 1'b0);
    push_plan(1, 8'hAB, 1'b1);
    steps(5);
    check("err_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b10, 1'b1, 8'hAB});
    steps(2);

    // Longest stall that still completes normally.
    post_req(0, 8'h9A, 8'h11, 1'b1);
    push_plan(TIMEOUT - 1, 8'h00, 1'b0);
    steps(TIMEOUT + 3);
    check("late_rsp", {bus.rsp_valid, bus.rsp_err}, {2'b01, 1'b0});
    steps(2);

    // Stuck completer: watchdog abort.
    post_req(1, 8'hBC, 8'h00, 1'b0);
    push_plan(TIMEOUT, 8'hFF, 1'b0);
    steps(TIMEOUT + 3);
    check("abort_rsp", {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata},
          {1'b0, 2'b10, 1'b1, 8'h00});
    steps(3);

    // Reset during ACCESS, then pointer must restart at requester 0.
    post_req(0, 8'hCD, 8'h22, 1'b1);
    push_plan(5, 8'h00, 1'b0);
    steps(3);
    hold_reset = 1'b1;
    step();
    hold_reset = 1'b0;
    step();
    check("rst_bus", {bus.psel, bus.penable, bus.rsp_valid}, 4'b0000);
    post_req(1, 8'h0F, 8'h33, 1'b1);
    post_req(0, 8'hF0, 8'h44, 1'b0);
    step();
    check("rst_ptr", bus.req_ready, 2'b01);
    steps(8);

    // Contention: both requesters valid from reset, back-to-back zero-wait transfers.
    hold_reset = 1'b1;
    post_pct   = 100;
    for (int k = 0; k < 8; k++) push_plan(0, DATA_W'($urandom), 1'b0);
    step();
    hold_reset = 1'b0;
    rsp_seen   = 0;
    steps(25);
    check("contention_rsp", rsp_seen, 8);

    // Random traffic with occasional resets.
    post_pct = 40;
    for (int n = 0; n < 3000; n++) begin
      hold_reset = ($urandom_range(999) < 3);
      step();
    end
    hold_reset = 1'b0;
    post_pct   = 0;
    steps(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
